// File: rtl/trip_ctrl.sv
// trip_ctrl: taxi trip FSM (IDLE/DRIVE/WAIT/SETTLE) driving meter clear, distance, wait and display controls.
// Optional feature: define AUTO_WAIT_EN to enable the DRIVE idle-timeout into WAIT.
module trip_ctrl #(
    parameter int SETTLE_SEC = 10,
    parameter int DISP_SEC   = 3,
    parameter int IDLE_TMO   = 5
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_start,
    input  logic       key_wait,
    input  logic       key_end,
    input  logic       pulse_100m,
    input  logic       tick_1s,
    output logic       meter_clr,
    output logic       dist_inc,
    output logic       wait_en,
    output logic [1:0] disp_sel,
    output logic [1:0] state,
    output logic [7:0] trip_cnt
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;
    localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_SEC < 1 ? 1 : SETTLE_SEC) - 1);
    localparam logic [15:0] DISP_LAST   = 16'((DISP_SEC < 1 ? 1 : DISP_SEC) - 1);
    localparam bit DISP_HOLD = DISP_SEC < 1;

    logic [1:0]  state_n, disp_sel_n;
    logic [15:0] sec_cnt, sec_cnt_n, disp_cnt, disp_cnt_n;
    logic        chg, settle_tick, page_step, auto_tmo;

`ifdef AUTO_WAIT_EN
    localparam logic [15:0] IDLE_LAST = 16'((IDLE_TMO < 1 ? 1 : IDLE_TMO) - 1);
    logic [15:0] idle_cnt;
    assign auto_tmo = state == S_DRIVE && tick_1s && !pulse_100m && idle_cnt == IDLE_LAST;
    // idle-timeout seconds in DRIVE; any distance pulse or state change restarts it
    always_ff @(posedge sys_clk) begin
        if (sys_rst || chg || pulse_100m)
            idle_cnt <= '0;
        else if (state == S_DRIVE && tick_1s)
            idle_cnt <= idle_cnt + 16'd1;
    end
`else
    assign auto_tmo = 1'b0;
`endif

    // next state by priority key_end > key_wait > pulse_100m, then counter and display updates
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = key_start ? S_DRIVE : S_IDLE;
            S_DRIVE: state_n = key_end ? S_SETTLE : (key_wait || auto_tmo) ? S_WAIT : S_DRIVE;
            S_WAIT:  state_n = key_end ? S_SETTLE : (key_wait || pulse_100m) ? S_DRIVE : S_WAIT;
            default: state_n = key_start ? S_DRIVE : (tick_1s && sec_cnt == SETTLE_LAST) ? S_IDLE : S_SETTLE;
        endcase
        chg         = state_n != state;
        settle_tick = state == S_SETTLE && !chg && tick_1s;
        page_step   = settle_tick && !DISP_HOLD && disp_cnt == DISP_LAST;
        sec_cnt_n   = chg ? 16'd0 : settle_tick ? sec_cnt + 16'd1 : sec_cnt;
        disp_cnt_n  = chg ? 16'd0 : page_step ? 16'd0 : (settle_tick && !DISP_HOLD) ? disp_cnt + 16'd1 : disp_cnt;
        disp_sel_n  = state_n == S_IDLE ? 2'd3 :
                      (state_n != S_SETTLE || chg) ? 2'd0 :
                      page_step ? (disp_sel == 2'd2 ? 2'd0 : disp_sel + 2'd1) : disp_sel;
    end

    // registered outputs and counters; reset abandons any trip without counting it
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            meter_clr <= 1'b1;
            dist_inc  <= 1'b0;
            wait_en   <= 1'b0;
            disp_sel  <= 2'd3;
            trip_cnt  <= 8'd0;
            sec_cnt   <= 16'd0;
            disp_cnt  <= 16'd0;
        end else begin
            state     <= state_n;
            meter_clr <= state_n == S_DRIVE && (state == S_IDLE || state == S_SETTLE);
            dist_inc  <= pulse_100m && !key_end && (state == S_DRIVE || state == S_WAIT);
            wait_en   <= state_n == S_WAIT;
            disp_sel  <= disp_sel_n;
            trip_cnt  <= (state_n == S_SETTLE && state != S_SETTLE) ? trip_cnt + 8'd1 : trip_cnt;
            sec_cnt   <= sec_cnt_n;
            disp_cnt  <= disp_cnt_n;
        end
    end
endmodule

// File: tb/tb_trip_ctrl.sv
// tb_trip_ctrl: directed self-checking bench for trip_ctrl with default parameters.
module tb_trip_ctrl;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key_start = 1'b0, key_wait = 1'b0, key_end = 1'b0, pulse_100m = 1'b0, tick_1s = 1'b0;
    logic       meter_clr, dist_inc, wait_en;
    logic [1:0] disp_sel, state;
    logic [7:0] trip_cnt;
    logic [7:0] exp_trip = 8'd0;
    int         checks = 0;
    int         errors = 0;

    trip_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_start(key_start), .key_wait(key_wait),
        .key_end(key_end), .pulse_100m(pulse_100m), .tick_1s(tick_1s), .meter_clr(meter_clr),
        .dist_inc(dist_inc), .wait_en(wait_en), .disp_sel(disp_sel), .state(state), .trip_cnt(trip_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({state, meter_clr, dist_inc, wait_en, disp_sel, trip_cnt} !== {2'd0, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0}) begin
            errors++;
            $display("FAIL reset_state got st=%0d clr=%0d di=%0d we=%0d ds=%0d tc=%0d exp st=0 clr=1 di=0 we=0 ds=3 tc=0",
                     state, meter_clr, dist_inc, wait_en, disp_sel, trip_cnt);
        end
        sys_rst = 1'b0;
        cyc();
        checks++;
        if (meter_clr !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_clr got %0d exp 0", meter_clr);
        end
    endtask

    task automatic test_idle_ignore();
        key_wait = 1'b1; key_end = 1'b1; pulse_100m = 1'b1; tick_1s = 1'b1;
        cyc();
        key_wait = 1'b0; key_end = 1'b0; pulse_100m = 1'b0; tick_1s = 1'b0;
        checks++;
        if ({state, meter_clr, dist_inc, wait_en, disp_sel, trip_cnt} !== {2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 8'd0}) begin
            errors++;
            $display("FAIL idle_ignore got st=%0d clr=%0d di=%0d we=%0d ds=%0d tc=%0d exp 0 0 0 0 3 0",
                     state, meter_clr, dist_inc, wait_en, disp_sel, trip_cnt);
        end
    endtask

    task automatic test_start_dist();
        key_start = 1'b1;
        cyc();
        key_start = 1'b0;
        checks++;
        if ({state, meter_clr, disp_sel} !== {2'd1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL start got st=%0d clr=%0d ds=%0d exp st=1 clr=1 ds=0", state, meter_clr, disp_sel);
        end
        cyc();
        checks++;
        if (meter_clr !== 1'b0) begin
            errors++;
            $display("FAIL start_clr_single got %0d exp 0", meter_clr);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_100m = 1'b1;
            cyc();
            pulse_100m = 1'b0;
            checks++;
            if ({dist_inc, state} !== {1'b1, 2'd1}) begin
                errors++;
                $display("FAIL dist_inc_%0d got di=%0d st=%0d exp di=1 st=1", i, dist_inc, state);
            end
            cyc();
            checks++;
            if (dist_inc !== 1'b0) begin
                errors++;
                $display("FAIL dist_inc_drop_%0d got %0d exp 0", i, dist_inc);
            end
        end
    endtask

    task automatic test_wait();
        key_wait = 1'b1;
        cyc();
        key_wait = 1'b0;
        checks++;
        if ({state, wait_en, disp_sel} !== {2'd2, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL enter_wait got st=%0d we=%0d ds=%0d exp st=2 we=1 ds=0", state, wait_en, disp_sel);
        end
        pulse_100m = 1'b1;
        cyc();
        pulse_100m = 1'b0;
        checks++;
        if ({state, wait_en, dist_inc} !== {2'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL resume_pulse got st=%0d we=%0d di=%0d exp st=1 we=0 di=1", state, wait_en, dist_inc);
        end
    endtask

    task automatic test_settle();
        logic [1:0] exp_st, exp_ds;
        key_end = 1'b1; key_wait = 1'b1; tick_1s = 1'b1;
        cyc();
        key_end = 1'b0; key_wait = 1'b0; tick_1s = 1'b0;
        exp_trip++;
        checks++;
        if ({state, trip_cnt, disp_sel, wait_en} !== {2'd3, exp_trip, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL end_priority got st=%0d tc=%0d ds=%0d we=%0d exp st=3 tc=%0d ds=0 we=0",
                     state, trip_cnt, disp_sel, wait_en, exp_trip);
        end
        for (int i = 1; i <= 10; i++) begin
            tick_1s = 1'b1;
            cyc();
            tick_1s = 1'b0;
            exp_st = (i == 10) ? 2'd0 : 2'd3;
            exp_ds = (i == 10) ? 2'd3 : 2'((i / 3) % 3);
            checks++;
            if ({state, disp_sel} !== {exp_st, exp_ds}) begin
                errors++;
                $display("FAIL settle_tick_%0d got st=%0d ds=%0d exp st=%0d ds=%0d", i, state, disp_sel, exp_st, exp_ds);
            end
            cyc();
        end
    endtask

    task automatic test_wrap_restart();
        key_start = 1'b1;
        cyc();
        key_start = 1'b0;
        while (exp_trip != 8'd255) begin
            key_end = 1'b1;
            cyc();
            key_end = 1'b0;
            exp_trip++;
            key_start = 1'b1;
            cyc();
            key_start = 1'b0;
        end
        checks++;
        if ({state, trip_cnt} !== {2'd1, 8'd255}) begin
            errors++;
            $display("FAIL trip_255 got st=%0d tc=%0d exp st=1 tc=255", state, trip_cnt);
        end
        key_end = 1'b1;
        cyc();
        key_end = 1'b0;
        exp_trip++;
        checks++;
        if ({state, trip_cnt} !== {2'd3, 8'd0}) begin
            errors++;
            $display("FAIL trip_wrap got st=%0d tc=%0d exp st=3 tc=0", state, trip_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            tick_1s = 1'b1;
            cyc();
            tick_1s = 1'b0;
        end
        key_start = 1'b1; key_wait = 1'b1;
        cyc();
        key_start = 1'b0; key_wait = 1'b0;
        checks++;
        if ({state, meter_clr, disp_sel, wait_en} !== {2'd1, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL settle_restart got st=%0d clr=%0d ds=%0d we=%0d exp st=1 clr=1 ds=0 we=0",
                     state, meter_clr, disp_sel, wait_en);
        end
        key_end = 1'b1;
        cyc();
        key_end = 1'b0;
        exp_trip++;
        for (int i = 0; i < 9; i++) begin
            tick_1s = 1'b1;
            cyc();
            tick_1s = 1'b0;
        end
        checks++;
        if ({state, trip_cnt} !== {2'd3, exp_trip}) begin
            errors++;
            $display("FAIL settle_9_ticks got st=%0d tc=%0d exp st=3 tc=%0d", state, trip_cnt, exp_trip);
        end
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
        checks++;
        if ({state, disp_sel} !== {2'd0, 2'd3}) begin
            errors++;
            $display("FAIL settle_10th_tick got st=%0d ds=%0d exp st=0 ds=3", state, disp_sel);
        end
    endtask

    task automatic test_auto_wait();
        key_start = 1'b1;
        cyc();
        key_start = 1'b0;
`ifdef AUTO_WAIT_EN
        for (int i = 0; i < 4; i++) begin
            tick_1s = 1'b1;
            cyc();
            tick_1s = 1'b0;
        end
        pulse_100m = 1'b1;
        cyc();
        pulse_100m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick_1s = 1'b1;
            cyc();
            tick_1s = 1'b0;
        end
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL auto_restart got st=%0d exp 1", state);
        end
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
        checks++;
        if ({state, wait_en} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL auto_wait got st=%0d we=%0d exp st=2 we=1", state, wait_en);
        end
`else
        for (int i = 0; i < 20; i++) begin
            tick_1s = 1'b1;
            cyc();
            tick_1s = 1'b0;
        end
        checks++;
        if ({state, wait_en} !== {2'd1, 1'b0}) begin
            errors++;
            $display("FAIL no_auto_wait got st=%0d we=%0d exp st=1 we=0", state, wait_en);
        end
        key_wait = 1'b1;
        cyc();
        key_wait = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_trip();
        checks++;
        if ({state, wait_en} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_wait got st=%0d we=%0d exp st=2 we=1", state, wait_en);
        end
        sys_rst = 1'b1;
        cyc();
        sys_rst = 1'b0;
        checks++;
        if ({state, wait_en, meter_clr, disp_sel, trip_cnt} !== {2'd0, 1'b0, 1'b1, 2'd3, 8'd0}) begin
            errors++;
            $display("FAIL reset_in_wait got st=%0d we=%0d clr=%0d ds=%0d tc=%0d exp st=0 we=0 clr=1 ds=3 tc=0",
                     state, wait_en, meter_clr, disp_sel, trip_cnt);
        end
        cyc();
        checks++;
        if ({state, meter_clr} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_wait_release got st=%0d clr=%0d exp st=0 clr=0", state, meter_clr);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_start_dist();
        test_wait();
        test_settle();
        test_wrap_restart();
        test_auto_wait();
        test_reset_mid_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
